// File: rtl/cond_exec_unit.sv
// Execute-stage conditional execution: NZCV banks, condition gating, predicated blocks.
// Strobes and cond_ex are registered; flags_out reads the selected bank directly.
module cond_exec_unit #(
    parameter int NUM_CTX = 2,
    parameter int MAX_BLK = 4,
    parameter int CTX_W   = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1,
    parameter int LEN_W   = $clog2(MAX_BLK + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_in,
    input  logic [3:0]         cond,
    input  logic [CTX_W-1:0]   ctx_sel,
    input  logic [3:0]         alu_flags,
    input  logic [1:0]         flag_wr,
    input  logic               reg_write_in,
    input  logic               mem_write_in,
    input  logic               pc_src_in,
    input  logic               blk_start,
    input  logic [LEN_W-1:0]   blk_len,
    input  logic [MAX_BLK-1:0] blk_mask,
    output logic               reg_write,
    output logic               mem_write,
    output logic               pc_src,
    output logic               cond_ex,
    output logic [3:0]         flags_out,
    output logic               blk_active,
    output logic [LEN_W-1:0]   blk_remaining
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_BLK);

    state_t             state_q;
    logic [3:0]         flags_q [NUM_CTX];
    logic [3:0]         blk_cond_q;
    logic [MAX_BLK-1:0] blk_mask_q;
    logic [LEN_W-1:0]   blk_len_q;
    logic [LEN_W-1:0]   blk_rem_q;

    logic [3:0]         sel_flags;
    logic [LEN_W-1:0]   slot_idx;
    logic [MAX_BLK-1:0] mask_sh;
    logic               in_blk;
    logic               base;
    logic               e;
    logic               start_ok;
    logic [LEN_W-1:0]   len_clamp;

    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        unique case (c)
            4'b0000: return z;
            4'b0001: return ~z;
            4'b0010: return cf;
            4'b0011: return ~cf;
            4'b0100: return n;
            4'b0101: return ~n;
            4'b0110: return v;
            4'b0111: return ~v;
            4'b1000: return cf & ~z;
            4'b1001: return ~cf | z;
            4'b1010: return n == v;
            4'b1011: return n != v;
            4'b1100: return ~z & (n == v);
            4'b1101: return z | (n != v);
            4'b1110: return 1'b1;
            4'b1111: return 1'b0;
        endcase
    endfunction

    always_comb begin
        sel_flags = '0;
        for (int i = 0; i < NUM_CTX; i++)
            if (ctx_sel == CTX_W'(i)) sel_flags = flags_q[i];
    end

    // Slot polarity comes from the stored mask, indexed by slots already consumed.
    assign in_blk    = (state_q == ACTIVE);
    assign slot_idx  = blk_len_q - blk_rem_q;
    assign mask_sh   = blk_mask_q >> slot_idx;
    assign base      = cond_eval(in_blk ? blk_cond_q : cond, sel_flags);
    assign e         = in_blk ? (mask_sh[0] ? base : ~base) : base;
    assign start_ok  = valid_in & blk_start & (blk_len != '0) & ~in_blk;
    assign len_clamp = (blk_len > MAX_L) ? MAX_L : blk_len;

    assign flags_out     = sel_flags;
    assign blk_active    = in_blk;
    assign blk_remaining = blk_rem_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            blk_cond_q <= '0;
            blk_mask_q <= '0;
            blk_len_q  <= '0;
            blk_rem_q  <= '0;
            reg_write  <= 1'b0;
            mem_write  <= 1'b0;
            pc_src     <= 1'b0;
            cond_ex    <= 1'b0;
            for (int i = 0; i < NUM_CTX; i++)
                flags_q[i] <= '0;
        end else begin
            if (valid_in) begin
                reg_write <= reg_write_in & e;
                mem_write <= mem_write_in & e;
                pc_src    <= pc_src_in & e;
                cond_ex   <= e;
                for (int i = 0; i < NUM_CTX; i++) begin
                    if (e && ctx_sel == CTX_W'(i)) begin
                        if (flag_wr[1]) flags_q[i][3:2] <= alu_flags[3:2];
                        if (flag_wr[0]) flags_q[i][1:0] <= alu_flags[1:0];
                    end
                end
            end else begin
                reg_write <= 1'b0;
                mem_write <= 1'b0;
                pc_src    <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_q    <= ACTIVE;
                        blk_cond_q <= cond;
                        blk_mask_q <= blk_mask;
                        blk_len_q  <= len_clamp;
                        blk_rem_q  <= len_clamp;
                    end
                end
                ACTIVE: begin
                    if (valid_in) begin
                        // A taken branch inside the block ends it early.
                        if ((pc_src_in & e) || blk_rem_q == LEN_W'(1)) begin
                            state_q   <= IDLE;
                            blk_rem_q <= '0;
                        end else begin
                            blk_rem_q <= blk_rem_q - LEN_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cond_exec_unit.sv
// Bench for cond_exec_unit: directed test-plan sequences then random traffic
// compared against a behavioural model of flags, conditions and blocks.
module tb_cond_exec_unit;

    localparam int NUM_CTX = 2;
    localparam int MAX_BLK = 4;
    localparam int CTX_W   = 1;
    localparam int LEN_W   = 3;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               valid_in = 1'b0;
    logic [3:0]         cond = '0;
    logic [CTX_W-1:0]   ctx_sel = '0;
    logic [3:0]         alu_flags = '0;
    logic [1:0]         flag_wr = '0;
    logic               reg_write_in = 1'b0;
    logic               mem_write_in = 1'b0;
    logic               pc_src_in = 1'b0;
    logic               blk_start = 1'b0;
    logic [LEN_W-1:0]   blk_len = '0;
    logic [MAX_BLK-1:0] blk_mask = '0;
    logic               reg_write, mem_write, pc_src, cond_ex;
    logic [3:0]         flags_out;
    logic               blk_active;
    logic [LEN_W-1:0]   blk_remaining;

    int checks = 0;
    int errors = 0;

    // model state
    bit [3:0] mflags [NUM_CTX];
    bit       m_open;
    int       m_rem, m_len;
    bit [7:0] m_mask;
    bit [3:0] m_base;
    bit       m_rw, m_mw, m_pc, m_cex;

    cond_exec_unit #(.NUM_CTX(NUM_CTX), .MAX_BLK(MAX_BLK)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .cond(cond),
        .ctx_sel(ctx_sel), .alu_flags(alu_flags), .flag_wr(flag_wr),
        .reg_write_in(reg_write_in), .mem_write_in(mem_write_in),
        .pc_src_in(pc_src_in), .blk_start(blk_start), .blk_len(blk_len),
        .blk_mask(blk_mask), .reg_write(reg_write), .mem_write(mem_write),
        .pc_src(pc_src), .cond_ex(cond_ex), .flags_out(flags_out),
        .blk_active(blk_active), .blk_remaining(blk_remaining)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Conditions come in pairs: odd codes invert the even one; 1110/1111 = always/never.
    function automatic bit ref_cond(input bit [3:0] c, input bit [3:0] f);
        bit n, z, cy, v, r;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cy;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cy && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1;
        endcase
        return c[0] ? !r : r;
    endfunction

    task automatic model_edge();
        bit e;
        int s, ln;
        if (!rst_n) begin
            foreach (mflags[i]) mflags[i] = 0;
            m_open = 0; m_rem = 0; m_len = 0; m_mask = 0; m_base = 0;
            m_rw = 0; m_mw = 0; m_pc = 0; m_cex = 0;
            return;
        end
        if (!valid_in) begin
            m_rw = 0; m_mw = 0; m_pc = 0;
            return;
        end
        if (m_open) begin
            s = m_len - m_rem;
            e = ref_cond(m_base, mflags[ctx_sel]);
            if (!m_mask[s]) e = !e;
        end else begin
            e = ref_cond(cond, mflags[ctx_sel]);
        end
        m_rw = reg_write_in && e;
        m_mw = mem_write_in && e;
        m_pc = pc_src_in && e;
        m_cex = e;
        if (e) begin
            if (flag_wr[1]) mflags[ctx_sel][3:2] = alu_flags[3:2];
            if (flag_wr[0]) mflags[ctx_sel][1:0] = alu_flags[1:0];
        end
        if (m_open) begin
            m_rem--;
            if (m_rem == 0 || (pc_src_in && e)) begin
                m_open = 0;
                m_rem = 0;
            end
        end else if (blk_start && blk_len != 0) begin
            ln = int'(blk_len);
            if (ln > MAX_BLK) ln = MAX_BLK;
            m_open = 1; m_len = ln; m_rem = ln;
            m_mask = 8'(blk_mask); m_base = cond;
        end
    endtask

    task automatic step(input bit v, input bit [3:0] c, input int ctx,
                        input bit [3:0] af, input bit [1:0] fw,
                        input bit rw, input bit pc, input bit bs,
                        input int bl, input bit [3:0] bm);
        @(negedge clk);
        valid_in = v; cond = c; ctx_sel = CTX_W'(ctx);
        alu_flags = af; flag_wr = fw; reg_write_in = rw;
        mem_write_in = rw ^ pc; pc_src_in = pc; blk_start = bs;
        blk_len = LEN_W'(bl); blk_mask = bm;
        model_edge();
        @(posedge clk);
        #1;
        chk("reg_write", reg_write, m_rw);
        chk("mem_write", mem_write, m_mw);
        chk("pc_src", pc_src, m_pc);
        chk("cond_ex", cond_ex, m_cex);
        chk("flags_out", flags_out, mflags[ctx_sel]);
        chk("blk_active", blk_active, m_open);
        chk("blk_remaining", blk_remaining, m_rem);
    endtask

    task automatic idle(input int ctx);
        step(0, 4'hE, ctx, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 0;
        idle(0);
        idle(0);
        chk("tp_rst_flags", flags_out, 4'b0000);
        chk("tp_rst_blk", blk_active, 1'b0);
        rst_n = 1;

        step(1, 4'b0000, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("tp_eq_z0", reg_write, 1'b0);
        step(1, 4'b1110, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("tp_al", reg_write, 1'b1);
        step(1, 4'b1111, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("tp_nv", reg_write, 1'b0);

        step(1, 4'b1110, 0, 4'b0100, 2'b11, 0, 0, 0, 0, 0);
        chk("tp_ctx0_wr", flags_out, 4'b0100);
        step(1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("tp_ctx0_eq", cond_ex, 1'b1);
        step(1, 4'b0000, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("tp_ctx1_eq", cond_ex, 1'b0);

        step(1, 4'b1110, 0, 4'b1010, 2'b11, 0, 0, 0, 0, 0);
        step(1, 4'b1110, 0, 4'b0101, 2'b10, 0, 0, 0, 0, 0);
        chk("tp_partial", flags_out, 4'b0110);
        step(1, 4'b1101, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("tp_le", cond_ex, 1'b1);
        step(1, 4'b1100, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("tp_gt", cond_ex, 1'b0);

        // block with mask 101 and idle gaps
        step(1, 4'b0000, 0, 0, 0, 0, 0, 1, 3, 4'b0101);
        chk("tp_blk_open", blk_remaining, 3);
        idle(0);
        chk("tp_blk_hold", blk_remaining, 3);
        step(1, 4'b1111, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("tp_slot0", reg_write, 1'b1);
        idle(0);
        step(1, 4'b1111, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("tp_slot1", reg_write, 1'b0);
        idle(0);
        step(1, 4'b1111, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("tp_slot2", reg_write, 1'b1);
        chk("tp_blk_done", blk_active, 1'b0);

        // branch abort
        step(1, 4'b0000, 0, 0, 0, 0, 0, 1, 4, 4'b1111);
        step(1, 4'b1111, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 4'b1111, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("tp_br_pc", pc_src, 1'b1);
        chk("tp_br_close", blk_active, 1'b0);
        step(1, 4'b1111, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("tp_br_own", reg_write, 1'b0);

        // clamp then reset mid-block
        step(1, 4'b1110, 0, 0, 0, 0, 0, 1, 7, 4'b1111);
        chk("tp_clamp", blk_remaining, 4);
        step(1, 4'b1110, 0, 0, 0, 1, 0, 0, 0, 0);
        rst_n = 0;
        step(1, 4'b1110, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("tp_rst_mid", blk_active, 1'b0);
        chk("tp_rst_rw", reg_write, 1'b0);
        chk("tp_rst_fl", flags_out, 4'b0000);
        rst_n = 1;

        for (int k = 0; k < 3000; k++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            step($urandom_range(0, 3) != 0,
                 4'($urandom), int'($urandom_range(0, NUM_CTX - 1)),
                 4'($urandom), 2'($urandom),
                 1'($urandom), $urandom_range(0, 5) == 0,
                 $urandom_range(0, 3) == 0, int'($urandom_range(0, 7)),
                 4'($urandom));
        end
        rst_n = 1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cond_exec_unit.md
Name: cond_exec_unit

Overview:
- Parametrised conditional-execution unit for the processor's execute stage; successor to the combinational condition checker.
- Holds NZCV flag registers for NUM_CTX contexts and evaluates the 4-bit condition field against the selected context's flags.
- Gates the write-back, memory-write and branch strobes, with one-cycle registered outputs.
- Adds predicated blocks: one start instruction predicates the next 1..MAX_BLK valid instructions with a then/else mask.

Parameters:
NUM_CTX, 2, number of independent NZCV flag banks (≥1)
MAX_BLK, 4, maximum predicated-block length (1..8)
CTX_W, $clog2(NUM_CTX) (min 1), context select width
LEN_W, $clog2(MAX_BLK+1), block length field width

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
valid_in  in  1  instruction present this cycle
cond  in  4  condition field
ctx_sel  in  CTX_W  flag bank used for evaluation and update
alu_flags  in  4  {N,Z,C,V} from ALU, bit3=N, bit2=Z, bit1=C, bit0=V
flag_wr  in  2  bit1: update N,Z; bit0: update C,V
reg_write_in  in  1  requested register write
mem_write_in  in  1  requested memory write
pc_src_in  in  1  requested branch/PC write
blk_start  in  1  instruction opens a predicated block
blk_len  in  LEN_W  number of following instructions predicated
blk_mask  in  MAX_BLK  per-slot polarity, bit i = slot i; 1 = base cond, 0 = inverse
reg_write  out  1  gated register write (registered)
mem_write  out  1  gated memory write (registered)
pc_src  out  1  gated branch (registered)
cond_ex  out  1  effective condition result of last valid instruction (registered)
flags_out  out  4  current flags of bank ctx_sel (combinational read of register)
blk_active  out  1  a block is open
blk_remaining  out  LEN_W  slots left in open block

Behaviour:
- Reset, sampled on rising clk with rst_n=0: all flag banks=4'b0000; block idle (blk_active=0, blk_remaining=0, stored mask/cond=0); reg_write, mem_write, pc_src, cond_ex=0. Reset mid-block abandons the block.
- Condition table, with flags from bank ctx_sel:
  - 0000 Z; 0001 ~Z; 0010 C; 0011 ~C; 0100 N; 0101 ~N; 0110 V; 0111 ~V.
  - 1000 C&~Z; 1001 ~C|Z; 1010 N==V; 1011 N!=V; 1100 ~Z&(N==V); 1101 Z|(N!=V).
  - 1110 always 1; 1111 never 0 (defined, no X).
- Effective condition E:
  - Outside a block, E = table(cond).
  - In block slot i (i = blk_len_stored - blk_remaining), E = table(stored base cond) if mask bit i=1, else its inverse. The instruction's own cond is ignored.
  - Evaluation always uses the flags at evaluation time, not those at block start.
- Outputs, latency 1: on a clock with valid_in=1, reg_write<=reg_write_in&E, mem_write<=mem_write_in&E, pc_src<=pc_src_in&E, cond_ex<=E. With valid_in=0, the three strobes<=0 and cond_ex holds.
- Flag update: on a clock with valid_in&E, bank ctx_sel takes N,Z from alu_flags if flag_wr[1], and C,V if flag_wr[0]. Other banks are unchanged. The update is visible to the next instruction (flags_out updates same edge).
- Block state machine, IDLE/ACTIVE:
  - IDLE→ACTIVE: valid_in&blk_start&blk_len≠0. Store cond as base, blk_mask, and length=min(blk_len,MAX_BLK); blk_remaining=length. The start instruction itself is evaluated normally with E=table(cond), and its strobes are gated.
  - blk_len=0: start ignored; instruction behaves normally.
  - ACTIVE: each valid_in decrements blk_remaining. On reaching 0, go to IDLE the same edge. valid_in=0 cycles do not advance.
  - blk_start while ACTIVE: start ignored (no nesting); the instruction is a normal slot.
  - Branch abort: a slot with pc_src_in&E=1 closes the block at that edge (blk_remaining<=0, IDLE) regardless of slots left.
- ctx_sel may change inside a block; each slot uses its own ctx_sel.

Test Plan:
- Reset then cond=0000, valid, reg_write_in=1 → flags_out=0000, E=0, reg_write=0 next cycle. Cond=1110 → reg_write=1; cond=1111 → 0.
- ctx0: alu_flags=0100, flag_wr=11, cond=1110 → ctx0 flags=0100. Next cond=0000 → cond_ex=1. ctx_sel=1 with same cond → cond_ex=0 (bank 1 untouched).
- Partial update: flags 1010, alu_flags=0101, flag_wr=10 → flags 0110. Cond 1101 (LE): Z=1 → 1. Cond 1100 (GT) → 0.
- Block: Z=1, blk_start cond=0000, len=3, mask=3'b101, then three valid reg_write_in=1 instructions with idle cycles between → reg_write 1,0,1; blk_remaining 3→2→1→0 only on valid cycles; blk_active drops after the third.
- Branch abort: len=4, mask=1111, Z=1; slot 1 with pc_src_in=1 → pc_src=1, block closes; next instruction uses its own cond.
- Clamp/reset: len=7 with MAX_BLK=4 → blk_remaining=4. Assert rst_n=0 after slot 1 → blk_active=0, all flags 0, outputs 0 next cycle.
